clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
- Run/stop and rate-reconfiguration controller for the board-level divided clock, e.g. the 1 Hz blink/timer clock.
- Owns the half-period counter and the divided output. Adds start/stop sequencing and a valid/ready configuration port.
- Applies a new rate only at a full-period boundary, so no runt pulses reach downstream logic.
- Sits between the top-level control logic (switches, menu FSM) and the slow-clock consumers.

Parameters:
W, 27, counter and rate-register width
DEFAULT_HALF, 50000000, reset value of the half-period register in clk_in cycles (1 Hz from 100 MHz)

Ports:
clk_in  input  1  system clock; all logic on the rising edge
rst  input  1  asynchronous, active-low reset
en  input  1  run request; level-sensitive
cfg_valid  input  1  new rate offered
cfg_half  input  W  requested half-period in clk_in cycles
cfg_ready  output  1  controller can accept a rate
clk_out  output  1  divided clock, registered
tick  output  1  one-cycle pulse on the cycle clk_out goes 0->1
busy  output  1  accepted rate is pending, not yet applied
err  output  1  one-cycle pulse: cfg_half==0 was rejected

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=1, half_reg=DEFAULT_HALF, pend_reg=0
  - clk_out=0, tick=0, busy=0, err=0, cfg_ready=1
- States: IDLE, RUN, STOP.
- IDLE:
  - clk_out held 0, counter held at 1.
  - en=1 -> RUN on the next cycle.
- RUN:
  - Each cycle: if counter>=half_reg then counter<=1 and clk_out<=~clk_out; else counter<=counter+1.
  - Each clk_out level therefore lasts half_reg cycles; period = 2*half_reg; half_reg=1 gives clk_in/2.
  - tick is registered and asserts the same cycle clk_out becomes 1.
  - en=0 -> STOP.
- STOP:
  - If clk_out=0: go to IDLE next cycle and reset counter to 1. Truncating the low phase is allowed.
  - If clk_out=1: keep counting. At the boundary clk_out falls to 0 and the state goes to IDLE.
  - en=1 while in STOP -> back to RUN with no disturbance to counter or clk_out.
- Configuration handshake:
  - A transfer occurs when cfg_valid && cfg_ready.
  - cfg_half==0: transfer completes but the value is discarded; err=1 for the next cycle; half_reg unchanged.
  - Accepted in IDLE: half_reg<=cfg_half next cycle; cfg_ready stays 1.
  - Accepted in RUN/STOP:
    - pend_reg<=cfg_half; busy<=1; cfg_ready<=0.
    - Applied at the next boundary where clk_out is 1 (the falling edge that ends a full period): half_reg<=pend_reg.
    - busy<=0 and cfg_ready<=1 on that same edge.
- Simultaneous events:
  - Accept coincides with a boundary: that boundary uses the old half_reg; the pending rate waits for the next falling edge.
  - STOP exits via its final falling edge with a change pending: the pending value is applied on that edge.
  - Entering IDLE from the truncated-low path with a change pending: the pending value is applied on the IDLE entry edge.
- Width: the counter is W bits and the compare is unsigned >=. half_reg changes only when counter is 1, so the counter never overruns.
- Reset mid-operation: all outputs return to reset values immediately and any pending rate is lost.

Test Plan (DEFAULT_HALF=4 unless stated):
- Release rst, en=1 -> RUN next cycle; clk_out rises on the 4th RUN cycle, falls 4 cycles later; tick every 8 cycles, 1 cycle wide.
- cfg_half=2 offered during a high phase -> accepted; busy=1 and cfg_ready=0 until the next falling edge. Afterwards clk_out period is 4 cycles (2 high, 2 low), then busy=0, cfg_ready=1.
- cfg_half=0 offered in RUN -> err=1 for exactly one cycle; period stays 8; busy stays 0.
- en=0 one cycle after clk_out rises -> high phase completes (4 cycles total), clk_out=0, IDLE. en=0 in a low phase -> IDLE next cycle, clk_out stays 0, counter=1.
- In IDLE offer cfg_half=3, then en=1 -> cfg_ready never drops; first rise on the 3rd RUN cycle; period 6.
- Assert rst low mid high-phase with busy=1 -> clk_out=0, busy=0, cfg_ready=1 immediately; after release with en=1, period is 8 (DEFAULT_HALF restored).

Source files
------------

// File: rtl/clk_div_ctrl_if.sv
// Rate-configuration handshake between control logic (master) and the divider (slave).
interface clk_div_ctrl_if #(
  parameter int W = 27
);
  logic         cfg_valid;
  logic [W-1:0] cfg_half;
  logic         cfg_ready;

  modport master (output cfg_valid, output cfg_half, input  cfg_ready);
  modport slave  (input  cfg_valid, input  cfg_half, output cfg_ready);
endinterface

// File: rtl/clk_div_ctrl.sv
// Run/stop divided-clock generator with a rate port whose updates land only on
// full-period boundaries, so consumers never see a runt pulse.
module clk_div_ctrl #(
  parameter int W            = 27,
  parameter int DEFAULT_HALF = 50000000
) (
  input  logic           clk_in,
  input  logic           rst,
  input  logic           en,
  clk_div_ctrl_if.slave  cfg,
  output logic           clk_out,
  output logic           tick,
  output logic           busy,
  output logic           err
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t       state_q;
  logic [W-1:0] cnt_q, half_q, pend_q;
  logic         clk_q, tick_q, busy_q, err_q, rdy_q;

  logic acc, acc_ok, bnd, count, fall, to_idle, idle_now;

  always_comb begin
    acc      = cfg.cfg_valid && rdy_q;
    acc_ok   = acc && (cfg.cfg_half != '0);
    bnd      = cnt_q >= half_q;
    // STOP keeps counting only to finish a high phase, or when re-armed by en
    count    = (state_q == RUN) || ((state_q == STOP) && (en || clk_q));
    fall     = count && bnd && clk_q;
    to_idle  = (state_q == STOP) && !en && (!clk_q || bnd);
    idle_now = (state_q == IDLE) || to_idle;
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= W'(1);
      half_q  <= W'(DEFAULT_HALF);
      pend_q  <= '0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      err_q  <= acc && !acc_ok;
      tick_q <= count && bnd && !clk_q;

      unique case (state_q)
        IDLE:    if (en) state_q <= RUN;
        RUN:     if (!en) state_q <= STOP;
        STOP:    if (en) state_q <= RUN;
                 else if (to_idle) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (count) begin
        if (bnd) begin
          cnt_q <= W'(1);
          clk_q <= ~clk_q;
        end else begin
          cnt_q <= cnt_q + W'(1);
        end
      end else begin
        cnt_q <= W'(1);
        clk_q <= 1'b0;
      end

      // Counter is parked at 1 whenever idle_now holds, so a direct write is safe.
      // rdy_q gates acceptance, so acc_ok and busy_q are never both set.
      if (acc_ok && idle_now) begin
        half_q <= cfg.cfg_half;
      end else if (acc_ok) begin
        pend_q <= cfg.cfg_half;
        busy_q <= 1'b1;
        rdy_q  <= 1'b0;
      end else if (busy_q && (fall || to_idle)) begin
        half_q <= pend_q;
        busy_q <= 1'b0;
        rdy_q  <= 1'b1;
      end
    end
  end

  assign clk_out       = clk_q;
  assign tick          = tick_q;
  assign busy          = busy_q;
  assign err           = err_q;
  assign cfg.cfg_ready = rdy_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboarded bench: a countdown-style reference model predicts the outputs
// after every clock edge; a negedge monitor pops and compares.
module tb_clk_div_ctrl;
  localparam int W  = 27;
  localparam int DH = 4;

  logic clk_in = 1'b0;
  logic rst    = 1'b0;
  logic en     = 1'b0;
  logic clk_out, tick, busy, err;

  clk_div_ctrl_if #(.W(W)) cfg ();

  clk_div_ctrl #(.W(W), .DEFAULT_HALF(DH)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .en     (en),
    .cfg    (cfg.slave),
    .clk_out(clk_out),
    .tick   (tick),
    .busy   (busy),
    .err    (err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {logic clk; logic tick; logic busy; logic err; logic rdy;} obs_t;

  obs_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Reference model: level + cycles remaining in that level; pending rates in a queue.
  typedef enum {M_IDLE, M_RUN, M_STOP} mmode_t;
  mmode_t mode;
  int     lvl, rem, m_half;
  bit     m_busy, m_rdy, m_err, m_tick;
  int     pend[$];

  function automatic void model_reset();
    mode = M_IDLE; lvl = 0; rem = 0; m_half = DH;
    m_busy = 0; m_rdy = 1; m_err = 0; m_tick = 0;
    pend.delete();
  endfunction

  function automatic obs_t exp_obs();
    obs_t o;
    o.clk = lvl[0]; o.tick = m_tick; o.busy = m_busy; o.err = m_err; o.rdy = m_rdy;
    return o;
  endfunction

  function automatic void model_step();
    bit acc, ok, counting, flip, falling, rising, enter_idle;
    mmode_t nmode;
    int h_in;
    if (!rst) begin
      model_reset();
      return;
    end
    h_in     = int'(cfg.cfg_half);
    acc      = cfg.cfg_valid && m_rdy;
    ok       = acc && (h_in != 0);
    counting = (mode == M_RUN) || (mode == M_STOP && (en || lvl == 1));
    flip     = 0;
    if (counting) begin
      if (rem == 0) rem = m_half;
      rem--;
      flip = (rem == 0);
    end
    falling = flip && lvl == 1;
    rising  = flip && lvl == 0;
    case (mode)
      M_IDLE:  nmode = en ? M_RUN : M_IDLE;
      M_RUN:   nmode = en ? M_RUN : M_STOP;
      default: nmode = en ? M_RUN : ((lvl == 0 || falling) ? M_IDLE : M_STOP);
    endcase
    enter_idle = (mode == M_STOP) && (nmode == M_IDLE);
    if (ok && (mode == M_IDLE || enter_idle)) m_half = h_in;
    else if (ok) begin
      pend.push_back(h_in); m_busy = 1; m_rdy = 0;
    end else if (m_busy && (falling || enter_idle)) begin
      m_half = pend.pop_front(); m_busy = 0; m_rdy = 1;
    end
    if (flip) lvl = 1 - lvl;
    if (!counting) lvl = 0;
    if (nmode == M_IDLE) rem = 0;
    m_err  = acc && !ok;
    m_tick = rising;
    mode   = nmode;
  endfunction

  always @(negedge clk_in) begin
    obs_t e, a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = {clk_out, tick, busy, err, cfg.cfg_ready};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL outputs cyc %0d: got clk/tick/busy/err/rdy=%b want %b", cyc, a, e);
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    cyc++;
    model_step();
    sb.push_back(exp_obs());
    #1;
  endtask

  task automatic drive(input bit e, input bit v, input int h);
    en = e;
    cfg.cfg_valid = v;
    cfg.cfg_half  = W'(h);
  endtask

  task automatic async_reset();
    @(negedge clk_in);
    #1 rst = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({clk_out, tick, busy, err, cfg.cfg_ready} !== 5'b00001) begin
      n_bad++;
      $display("FAIL async_reset: got clk/tick/busy/err/rdy=%b want 00001",
               {clk_out, tick, busy, err, cfg.cfg_ready});
    end
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic wait_high();
    for (int i = 0; i < 40; i++) begin
      if (lvl == 1) break;
      step();
    end
  endtask

  initial begin
    model_reset();
    drive(0, 0, 0);
    step(); step();
    rst = 1'b1;

    // free run at default rate
    drive(1, 0, 0);
    repeat (20) step();

    // rate change offered in a high phase
    wait_high();
    drive(1, 1, 2); step();
    drive(1, 0, 0); repeat (20) step();

    // zero rate rejected
    drive(1, 1, 0); step();
    drive(1, 0, 0); repeat (12) step();

    // restore 4, then stop one cycle after a rise
    drive(1, 1, 4); step();
    drive(1, 0, 0); repeat (12) step();
    for (int i = 0; i < 40; i++) begin
      if (m_tick) break;
      step();
    end
    step();
    drive(0, 0, 0); repeat (8) step();

    // stop during a low phase
    drive(1, 0, 0); repeat (2) step();
    drive(0, 0, 0); repeat (3) step();

    // rate set while idle
    drive(0, 1, 3); step();
    drive(1, 0, 0); repeat (20) step();

    // reset with a change pending
    wait_high();
    drive(1, 1, 5); step();
    drive(1, 0, 0); step();
    async_reset();
    repeat (20) step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 6));
      if ($urandom_range(0, 299) == 0) async_reset();
      else step();
    end

    drive(0, 0, 0);
    step();
    @(negedge clk_in);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
